// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port line-fill memory arbiter.
package mem_arb_pkg;
    localparam int LINE_W    = 256;
    localparam int BEAT_W    = 64;
    localparam int NUM_BEATS = 4;

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_e;
    typedef enum logic {OWN_I, OWN_D} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side signals of the arbiter; slave is the arbiter view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              i_read;
    logic [31:0]       i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [31:0]       d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_addr;
    logic [BEAT_W-1:0] pmem_wdata;
    logic [BEAT_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/line_burst_adapter.sv
// Beat counter plus line<->beat conversion: packs read beats, selects write beats.
module line_burst_adapter #(
    parameter int s_line  = 256,
    parameter int s_beat  = 64,
    parameter int n_beats = s_line / s_beat
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_beat_en,
    input  logic              i_rd_en,
    input  logic [s_beat-1:0] i_rdata,
    input  logic [s_line-1:0] i_wline,
    output logic [s_line-1:0] o_line,
    output logic [s_beat-1:0] o_wbeat,
    output logic              o_last
);
    localparam int CNT_W = $clog2(n_beats);

    logic [CNT_W-1:0]  r_cnt;
    logic [s_line-1:0] r_line;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_cnt <= '0;
        else if (i_start)   r_cnt <= '0;
        else if (i_beat_en) r_cnt <= r_cnt + 1'b1;
    end

    // Buffer keeps the last read line; write bursts leave it untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    r_line <= '0;
        else if (i_beat_en && i_rd_en) r_line[r_cnt*s_beat +: s_beat] <= i_rdata;
    end

    assign o_line  = r_line;
    assign o_wbeat = i_wline[r_cnt*s_beat +: s_beat];
    assign o_last  = (r_cnt == CNT_W'(n_beats - 1));
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache/dcache line requests onto one burst memory port.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is dcache-first priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int s_line  = LINE_W,
    parameter int s_beat  = BEAT_W,
    parameter int n_beats = s_line / s_beat
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int OFF_W = $clog2(s_line / 8);

    state_e            r_state, w_next;
    owner_e            r_owner, w_grant;
    logic [31-OFF_W:0] r_line_addr;
    logic [s_line-1:0] r_wdata;
    logic [31:0]       w_addr;
    logic              w_i_req, w_d_req, w_start, w_beat_en, w_last;
    logic [s_line-1:0] w_line;
    logic [s_beat-1:0] w_wbeat;

    assign w_i_req = bus.i_read;
    assign w_d_req = bus.d_read | bus.d_write;

`ifdef MEM_ARB_RR_EN
    owner_e r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_last <= OWN_I;
        else if (w_start) r_last <= w_grant;
    end

    always_comb begin
        w_grant = w_d_req ? OWN_D : OWN_I;
        if (w_d_req && w_i_req) w_grant = (r_last == OWN_D) ? OWN_I : OWN_D;
    end
`else
    assign w_grant = w_d_req ? OWN_D : OWN_I;
`endif

    assign w_addr    = (w_grant == OWN_D) ? bus.d_addr : bus.i_addr;
    assign w_beat_en = bus.pmem_resp & ((r_state == RD_BURST) | (r_state == WR_BURST));

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_start = 1'b1;
                    w_next  = (w_grant == OWN_D && bus.d_write) ? WR_BURST : RD_BURST;
                end
            end
            RD_BURST, WR_BURST: if (w_beat_en && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_owner     <= OWN_I;
            r_line_addr <= '0;
            r_wdata     <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_owner     <= w_grant;
                r_line_addr <= w_addr[31:OFF_W];
                r_wdata     <= bus.d_wdata;
            end
        end
    end

    line_burst_adapter #(.s_line(s_line), .s_beat(s_beat), .n_beats(n_beats)) u_adapter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_beat_en (w_beat_en),
        .i_rd_en   (r_state == RD_BURST),
        .i_rdata   (bus.pmem_rdata),
        .i_wline   (r_wdata),
        .o_line    (w_line),
        .o_wbeat   (w_wbeat),
        .o_last    (w_last)
    );

    assign bus.pmem_read  = (r_state == RD_BURST);
    assign bus.pmem_write = (r_state == WR_BURST);
    assign bus.pmem_addr  = {r_line_addr, {OFF_W{1'b0}}};
    assign bus.pmem_wdata = w_wbeat;
    assign bus.i_resp     = (r_state == DONE) && (r_owner == OWN_I);
    assign bus.d_resp     = (r_state == DONE) && (r_owner == OWN_D);
    assign bus.i_rdata    = w_line;
    assign bus.d_rdata    = w_line;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model, burst memory model,
// directed scenarios with literal expectations and a randomized soak.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if bus();
    mem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    localparam logic [255:0] LINE_PAT =
        256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [63:0] pat(input int k);
        logic [7:0] b;
        b = 8'(17 * (k + 1));
        return {8{b}};
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Arbitration rule: dcache first, or alternate on contention when round-robin.
    function automatic bit pick_d(input bit iq, input bit dq, input bit last_d);
`ifdef MEM_ARB_RR_EN
        return (iq && dq) ? !last_d : dq;
`else
        return dq | (iq & last_d & 1'b0);
`endif
    endfunction

    // ---------------- reference model (transaction level) ----------------
    int           m_phase = 0;  // 0 waiting, 1 transferring, 2 reporting
    int           m_left  = 0;  // beats still to move
    bit           m_own_d = 1'b0, m_wr = 1'b0, m_last_d = 1'b0;
    logic [31:0]  m_addr  = '0;
    logic [255:0] m_wdata = '0;
    logic [63:0]  m_beat [4] = '{default: '0};
    logic [255:0] m_line;
    bit           m_pick;

    assign m_line = {m_beat[3], m_beat[2], m_beat[1], m_beat[0]};
    assign m_pick = pick_d(bus.i_read, bus.d_read | bus.d_write, m_last_d);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= 0;
            m_left   <= 0;
            m_last_d <= 1'b0;
            m_beat   <= '{default: '0};
        end else if (m_phase == 0) begin
            if (bus.i_read || bus.d_read || bus.d_write) begin
                m_own_d  <= m_pick;
                m_last_d <= m_pick;
                m_wr     <= m_pick && bus.d_write;
                m_addr   <= m_pick ? bus.d_addr : bus.i_addr;
                m_wdata  <= bus.d_wdata;
                m_left   <= 4;
                m_phase  <= 1;
            end
        end else if (m_phase == 1) begin
            if (bus.pmem_resp) begin
                if (!m_wr) m_beat[4 - m_left] <= bus.pmem_rdata;
                m_left <= m_left - 1;
                if (m_left == 1) m_phase <= 2;
            end
        end else begin
            m_phase <= 0;
        end
    end

    // ---------------- memory model ----------------
    int mem_period = 1;
    bit rand_mode = 1'b0, stray_en = 1'b0;
    logic [63:0] wq[$];

    initial begin
        int wcnt, tgt, k;
        wcnt = 0; tgt = 0; k = 0;
        bus.pmem_resp = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.pmem_resp = 1'b0;
                wcnt = 0; k = 0;
                tgt = mem_period - 1;
            end else if (bus.pmem_read || bus.pmem_write) begin
                if (wcnt >= tgt) begin
                    bus.pmem_resp  = 1'b1;
                    bus.pmem_rdata = rand_mode ? {$urandom, $urandom} : pat(k);
                    if (bus.pmem_write) wq.push_back(bus.pmem_wdata);
                    k++; wcnt = 0;
                    tgt = rand_mode ? int'($urandom_range(0, 2)) : mem_period - 1;
                end else begin
                    bus.pmem_resp = 1'b0;
                    wcnt++;
                end
            end else begin
                // Stray beats outside a burst must be ignored by the arbiter.
                bus.pmem_resp  = stray_en && ($urandom_range(0, 3) == 0);
                bus.pmem_rdata = {$urandom, $urandom};
                wcnt = 0; k = 0;
                tgt = rand_mode ? int'($urandom_range(0, 2)) : mem_period - 1;
            end
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("pmem_read", bus.pmem_read, m_phase == 1 && !m_wr);
            chk("pmem_write", bus.pmem_write, m_phase == 1 && m_wr);
            chk("i_resp", bus.i_resp, m_phase == 2 && !m_own_d);
            chk("d_resp", bus.d_resp, m_phase == 2 && m_own_d);
            chk("i_rdata", bus.i_rdata, m_line);
            chk("d_rdata", bus.d_rdata, m_line);
            if (m_phase == 1) begin
                chk("pmem_addr", bus.pmem_addr, {m_addr[31:5], 5'b0});
                if (m_wr) chk("pmem_wdata", bus.pmem_wdata, m_wdata[64*(4-m_left) +: 64]);
            end
        end
    end

    // ---------------- burst / pulse monitor ----------------
    logic [31:0] alog[$];
    int wr_cyc = 0, i_pulses = 0, d_pulses = 0;

    initial begin
        bit was_busy;
        was_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) was_busy = 1'b0;
            else begin
                if ((bus.pmem_read || bus.pmem_write) && !was_busy) alog.push_back(bus.pmem_addr);
                was_busy = bus.pmem_read || bus.pmem_write;
                if (bus.pmem_write) wr_cyc++;
                if (bus.i_resp) i_pulses++;
                if (bus.d_resp) d_pulses++;
            end
        end
    end

    task automatic clear_mon();
        alog.delete(); wq.delete();
        wr_cyc = 0; i_pulses = 0; d_pulses = 0;
    endtask

    // Present requests, hold each until its resp, report resp cycle (request cycle = 1).
    task automatic run_req(input bit do_i, input bit do_d, input bit d_wr,
                           input logic [31:0] ia, input logic [31:0] da, input logic [255:0] wd,
                           output int i_cyc, output int d_cyc);
        bit pi, pd;
        int cyc;
        @(negedge clk);
        bus.i_read = do_i; bus.i_addr = ia;
        bus.d_read = do_d && !d_wr; bus.d_write = do_d && d_wr;
        bus.d_addr = da; bus.d_wdata = wd;
        pi = do_i; pd = do_d; cyc = 1; i_cyc = 0; d_cyc = 0;
        while ((pi || pd) && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pi && bus.i_resp) begin i_cyc = cyc; pi = 1'b0; bus.i_read = 1'b0; end
            if (pd && bus.d_resp) begin d_cyc = cyc; pd = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0; end
        end
        if (pi || pd) begin
            chk("req_timeout", {pi, pd}, 2'b00);
            bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        end
    endtask

    task automatic start_d();
        bit wr;
        wr = $urandom_range(0, 1) != 0;
        bus.d_read = !wr; bus.d_write = wr;
        bus.d_addr = $urandom; bus.d_wdata = rnd256();
    endtask

    initial begin
        int ic, dc, ip, dp;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

        #12;
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_i_resp", bus.i_resp, 0);
        chk("rst_d_resp", bus.d_resp, 0);
        chk("rst_pmem_addr", bus.pmem_addr, 0);
        chk("rst_pmem_wdata", bus.pmem_wdata, 0);
        chk("rst_i_rdata", bus.i_rdata, 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // icache fill, back-to-back beats
        clear_mon();
        run_req(1, 0, 0, 32'h0000_1234, '0, '0, ic, dc);
        repeat (3) @(negedge clk);
        chk("t1_latency", ic, 6);
        chk("t1_addr", alog[0], 32'h0000_1220);
        chk("t1_i_rdata", bus.i_rdata, LINE_PAT);
        chk("t1_model_line", m_line, LINE_PAT);
        chk("t1_i_pulses", i_pulses, 1);
        chk("t1_d_pulses", d_pulses, 0);

        // dcache write-back
        clear_mon();
        run_req(0, 1, 1, '0, 32'h8000_00E0, {64'd4, 64'd3, 64'd2, 64'd1}, ic, dc);
        repeat (3) @(negedge clk);
        chk("t2_addr", alog[0], 32'h8000_00E0);
        chk("t2_wr_cycles", wr_cyc, 4);
        chk("t2_nbeats", wq.size(), 4);
        for (int k = 0; k < 4; k++) chk("t2_wbeat", wq[k], 64'(k + 1));
        chk("t2_d_pulses", d_pulses, 1);
        chk("t2_i_pulses", i_pulses, 0);
        chk("t2_line_kept", bus.d_rdata, LINE_PAT);

        // simultaneous reads
        clear_mon();
        run_req(1, 1, 0, 32'h0000_0100, 32'h0000_0200, '0, ic, dc);
        repeat (3) @(negedge clk);
`ifdef MEM_ARB_RR_EN
        chk("t3_first", alog[0], 32'h0000_0100);
        chk("t3_second", alog[1], 32'h0000_0200);
        chk("t3_i_cyc", ic, 6);
        chk("t3_d_cyc", dc, 12);
`else
        chk("t3_first", alog[0], 32'h0000_0200);
        chk("t3_second", alog[1], 32'h0000_0100);
        chk("t3_d_cyc", dc, 6);
        chk("t3_i_cyc", ic, 12);
`endif

        // slow memory: 3 cycles per beat
        clear_mon();
        mem_period = 3;
        run_req(1, 0, 0, 32'h0000_5678, '0, '0, ic, dc);
        repeat (3) @(negedge clk);
        chk("t4_latency", ic, 14);
        chk("t4_addr", alog[0], 32'h0000_5660);
        chk("t4_nburst", alog.size(), 1);
        mem_period = 1;

        // reset after two beats of a read
        clear_mon();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_4000;
        repeat (3) @(negedge clk);
        chk("t5_busy_before", bus.pmem_read, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_pmem_read", bus.pmem_read, 0);
        chk("t5_i_resp", bus.i_resp, 0);
        chk("t5_pmem_addr", bus.pmem_addr, 0);
        chk("t5_i_rdata", bus.i_rdata, 0);
        bus.i_read = 1'b0;
        ip = i_pulses; dp = d_pulses;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t5_no_resp", i_pulses + d_pulses, ip + dp);
        run_req(1, 0, 0, 32'h0000_1234, '0, '0, ic, dc);
        repeat (2) @(negedge clk);
        chk("t5_restart_latency", ic, 6);
        chk("t5_restart_line", bus.i_rdata, LINE_PAT);

        // both ports requesting continuously (last served is icache here)
        clear_mon();
        @(negedge clk);
        bus.i_read = 1'b1; bus.i_addr = 32'h0000_0100;
        bus.d_read = 1'b1; bus.d_addr = 32'h0000_0200;
        repeat (30) @(negedge clk);
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_nburst_ge4", alog.size() >= 4, 1);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            chk("t6_grant", alog[k], (k % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
`else
            chk("t6_grant", alog[k], 32'h0000_0200);
`endif
        end

        // randomized soak against the model
        rand_mode = 1'b1; stray_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (bus.i_resp) begin
                if ($urandom_range(0, 1) == 0) bus.i_read = 1'b0;
                else bus.i_addr = $urandom;
            end else if (!bus.i_read) begin
                if ($urandom_range(0, 3) == 0) begin bus.i_read = 1'b1; bus.i_addr = $urandom; end
            end else if (m_phase != 0 && m_own_d) begin
                bus.i_addr = $urandom;
            end
            if (bus.d_resp) begin
                bus.d_read = 1'b0; bus.d_write = 1'b0;
                if ($urandom_range(0, 1) == 0) start_d();
            end else if (!(bus.d_read || bus.d_write)) begin
                if ($urandom_range(0, 3) == 0) start_d();
            end else if (m_phase != 0 && !m_own_d) begin
                bus.d_addr = $urandom; bus.d_wdata = rnd256();
            end
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
        repeat (30) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
